// File: rtl/imem_fetch_unit_if.sv
// rtl/imem_fetch_unit_if.sv - fetch request / response channel between PC stage and instruction store
interface imem_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_pc;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [INSTR_WIDTH-1:0] resp_instr;
  logic [ADDR_WIDTH-1:0]  resp_pc;
  logic [1:0]             resp_fault;

  modport master (
    output req_valid, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_pc, resp_fault
  );

  modport slave (
    input  req_valid, req_pc, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_pc, resp_fault
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - synchronous instruction store with fetch FIFO, load port, flush and fault codes
// Define IMEM_PARITY_EN to store an even-parity bit per word and report mismatches as fault 11.
module imem_fetch_unit #(
  parameter int IMEM_DEPTH  = 256,
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RESP_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  imem_fetch_unit_if.slave              fetch,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]        load_data,
  input  logic                          flush,
`ifdef IMEM_PARITY_EN
  input  logic                          inject_parity_err,
`endif
  output logic [31:0]                   fetch_cnt
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(RESP_DEPTH);

  logic [INSTR_WIDTH-1:0] mem [IMEM_DEPTH];
`ifdef IMEM_PARITY_EN
  logic                   par_mem [IMEM_DEPTH];
`endif

  logic [INSTR_WIDTH-1:0] q_instr [RESP_DEPTH];
  logic [ADDR_WIDTH-1:0]  q_pc    [RESP_DEPTH];
  logic [1:0]             q_fault [RESP_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            count;

  logic                   accept, pop;
  logic [ADDR_WIDTH-1:0]  word_idx;
  logic [AW-1:0]          mem_idx;
  logic [1:0]             rd_fault;
  logic [INSTR_WIDTH-1:0] rd_instr;

  assign word_idx = fetch.req_pc >> 2;
  assign mem_idx  = word_idx[AW-1:0];

  // The array is only touched for a clean request; faulting entries carry zero data.
  always_comb begin
    rd_fault = 2'b00;
    rd_instr = '0;
    if (fetch.req_pc[1:0] != 2'b00) begin
      rd_fault = 2'b01;
    end else if (word_idx >= ADDR_WIDTH'(IMEM_DEPTH)) begin
      rd_fault = 2'b10;
    end else begin
      rd_instr = mem[mem_idx];
`ifdef IMEM_PARITY_EN
      if ((^mem[mem_idx]) != par_mem[mem_idx]) rd_fault = 2'b11;
`endif
    end
  end

  // A pop in the same cycle does not open a slot for this cycle's request.
  assign fetch.req_ready = rst_n && !load_en && !flush && (count < (PW+1)'(RESP_DEPTH));
  assign accept = fetch.req_valid && fetch.req_ready;
  assign pop    = fetch.resp_valid && fetch.resp_ready;

  assign fetch.resp_valid = (count != '0);
  assign fetch.resp_instr = q_instr[rd_ptr];
  assign fetch.resp_pc    = q_pc[rd_ptr];
  assign fetch.resp_fault = q_fault[rd_ptr];

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
`ifdef IMEM_PARITY_EN
      par_mem[load_addr] <= (^load_data) ^ inject_parity_err;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fetch_cnt <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_fault[i] <= 2'b00;
      end
    end else begin
      if (pop) fetch_cnt <= fetch_cnt + 32'd1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) begin
          q_instr[wr_ptr] <= rd_instr;
          q_pc[wr_ptr]    <= fetch.req_pc;
          q_fault[wr_ptr] <= rd_fault;
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + (PW+1)'(accept) - (PW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - directed self-checking bench for imem_fetch_unit
module tb_imem_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        flush;
  logic [31:0] fetch_cnt;
`ifdef IMEM_PARITY_EN
  logic        inject_parity_err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] w [4];
  logic [31:0] t_pc [4];
  logic [31:0] t_instr [4];
  logic [1:0]  t_fault [4];

  imem_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) f ();

  imem_fetch_unit #(.IMEM_DEPTH(256), .INSTR_WIDTH(32), .ADDR_WIDTH(32), .RESP_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (f),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .flush     (flush),
`ifdef IMEM_PARITY_EN
    .inject_parity_err (inject_parity_err),
`endif
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [1:0] fault);
    chk({tag, " valid"}, 64'(f.resp_valid), 64'd1);
    chk({tag, " instr"}, 64'(f.resp_instr), 64'(instr));
    chk({tag, " pc"},    64'(f.resp_pc),    64'(pc));
    chk({tag, " fault"}, 64'(f.resp_fault), 64'(fault));
  endtask

  initial begin
    w[0] = 32'h00000033; w[1] = 32'h40000033; w[2] = 32'h00F00013; w[3] = 32'h0000006F;
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; flush = 1'b0;
    f.req_valid = 1'b0; f.req_pc = '0; f.resp_ready = 1'b0;
    step(); step();
    chk("rst req_ready",  64'(f.req_ready),  64'd0);
    chk("rst resp_valid", 64'(f.resp_valid), 64'd0);
    chk("rst resp_instr", 64'(f.resp_instr), 64'd0);
    chk("rst resp_pc",    64'(f.resp_pc),    64'd0);
    chk("rst resp_fault", 64'(f.resp_fault), 64'd0);
    chk("rst fetch_cnt",  64'(fetch_cnt),    64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step();
      load_en = 1'b1; load_addr = 8'(i); load_data = w[i];
      #1 chk("load blocks ready", 64'(f.req_ready), 64'd0);
    end
    step();
    load_en = 1'b0;

    // back-to-back fetch of words 0..3
    f.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      f.req_valid = (i < 4);
      f.req_pc    = 32'(4 * i);
      #1;
      if (i > 0) chk_head("b2b", w[i-1], 32'(4 * (i - 1)), 2'b00);
      if (i < 4) chk("b2b req_ready", 64'(f.req_ready), 64'd1);
    end
    step();
    chk("b2b drained", 64'(f.resp_valid), 64'd0);
    chk("b2b fetch_cnt", 64'(fetch_cnt), 64'd4);

    // faults interleaved with valid fetches
    t_pc[0] = 32'h0;   t_instr[0] = w[0];  t_fault[0] = 2'b00;
    t_pc[1] = 32'h6;   t_instr[1] = 32'h0; t_fault[1] = 2'b01;
    t_pc[2] = 32'h400; t_instr[2] = 32'h0; t_fault[2] = 2'b10;
    t_pc[3] = 32'h4;   t_instr[3] = w[1];  t_fault[3] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      f.req_valid = (i < 4);
      if (i < 4) f.req_pc = t_pc[i];
      #1;
      if (i > 0) chk_head("fault", t_instr[i-1], t_pc[i-1], t_fault[i-1]);
      step();
    end
    chk("fault fetch_cnt", 64'(fetch_cnt), 64'd8);

    // backpressure: two accepted, third stalls, head stable
    f.resp_ready = 1'b0; f.req_valid = 1'b1; f.req_pc = 32'h8;
    #1 chk("bp ready0", 64'(f.req_ready), 64'd1);
    step(); f.req_pc = 32'hC;
    #1 chk("bp ready1", 64'(f.req_ready), 64'd1);
    step(); f.req_pc = 32'h0;
    #1 chk("bp full", 64'(f.req_ready), 64'd0);
    chk_head("bp head", w[2], 32'h8, 2'b00);
    step();
    chk("bp still full", 64'(f.req_ready), 64'd0);
    chk_head("bp stable", w[2], 32'h8, 2'b00);
    f.resp_ready = 1'b1;
    #1 chk("bp pop no free", 64'(f.req_ready), 64'd0);
    step();
    chk("bp freed", 64'(f.req_ready), 64'd1);
    chk_head("bp second", w[3], 32'hC, 2'b00);
    step(); f.req_valid = 1'b0;
    #1 chk_head("bp third", w[0], 32'h0, 2'b00);
    step();
    chk("bp drained", 64'(f.resp_valid), 64'd0);
    chk("bp fetch_cnt", 64'(fetch_cnt), 64'd11);

    // flush with two buffered; head handed off in the flush cycle still counts
    f.resp_ready = 1'b0; f.req_valid = 1'b1; f.req_pc = 32'h0;
    step(); f.req_pc = 32'h4;
    step(); f.req_valid = 1'b0; flush = 1'b1; f.resp_ready = 1'b1;
    #1 chk("flush ready", 64'(f.req_ready), 64'd0);
    chk("flush cycle valid", 64'(f.resp_valid), 64'd1);
    step(); flush = 1'b0; f.req_valid = 1'b1; f.req_pc = 32'h8;
    #1 chk("flush empty", 64'(f.resp_valid), 64'd0);
    chk("flush fetch_cnt", 64'(fetch_cnt), 64'd12);
    step(); f.req_valid = 1'b0;
    #1 chk_head("post flush", w[2], 32'h8, 2'b00);
    step();
    chk("post flush drained", 64'(f.resp_valid), 64'd0);
    chk("post flush cnt", 64'(fetch_cnt), 64'd13);

    // load collides with a fetch request
    load_en = 1'b1; load_addr = 8'd1; load_data = 32'h12345678;
    f.req_valid = 1'b1; f.req_pc = 32'h4;
    #1 chk("load ready", 64'(f.req_ready), 64'd0);
    step(); load_en = 1'b0;
    #1 chk("load no accept", 64'(f.resp_valid), 64'd0);
    chk("after load ready", 64'(f.req_ready), 64'd1);
    step(); f.req_valid = 1'b0;
    #1 chk_head("reload", 32'h12345678, 32'h4, 2'b00);
    step();
    chk("reload cnt", 64'(fetch_cnt), 64'd14);

    // reset mid-burst
    f.resp_ready = 1'b0; f.req_valid = 1'b1; f.req_pc = 32'h0;
    step(); f.req_pc = 32'h8;
    step(); f.req_valid = 1'b0;
    #1 chk("pre rst valid", 64'(f.resp_valid), 64'd1);
    rst_n = 1'b0;
    #1 chk("mid rst valid", 64'(f.resp_valid), 64'd0);
    chk("mid rst cnt", 64'(fetch_cnt), 64'd0);
    chk("mid rst ready", 64'(f.req_ready), 64'd0);
    step(); rst_n = 1'b1; f.req_valid = 1'b1; f.req_pc = 32'h4; f.resp_ready = 1'b1;
    step(); f.req_valid = 1'b0;
    #1 chk_head("post rst", 32'h12345678, 32'h4, 2'b00);
    step();
    chk("post rst cnt", 64'(fetch_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
